// File: rtl/pc_sequencer.sv
// Program counter sequencer for the multicycle MIPS core: next-PC selection,
// misaligned-target redirect and a circular return-address stack.
// Optional trace outputs are enabled with `define PC_SEQUENCER_TRACE_EN.
module pc_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0180,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write_enable,
  input  logic [2:0]        pc_source,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              ras_push,
  output logic [ADDR_W-1:0] current_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misaligned,
  output logic [ADDR_W-1:0] exc_epc,
  output logic [ADDR_W-1:0] prev_pc,
  output logic [15:0]       update_count
);

  localparam int unsigned       PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned       CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC   = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC     = EXC_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'b000,
    SRC_BRANCH = 3'b001,
    SRC_JUMP   = 3'b010,
    SRC_REG    = 3'b011,
    SRC_RAS    = 3'b100,
    SRC_EXC    = 3'b101
  } pc_src_e;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] epc_q;
  logic              misaligned_q;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [CNT_W-1:0]  ras_cnt;
  logic [PTR_W-1:0]  top_idx;

  logic [ADDR_W-1:0] target;
  logic              src_valid;
  logic              pop_req;
  logic              commit;
  logic              do_push;
  logic              do_pop;
  logic              bad_align;

  // ras_ptr addresses the next free slot, so the top lives one below it.
  assign top_idx    = ras_ptr - PTR_W'(1);
  assign current_pc = pc_q;
  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign ras_empty  = (ras_cnt == '0);
  assign ras_full   = (ras_cnt == FULL_CNT);
  assign ras_top    = ras_empty ? '0 : ras_mem[top_idx];
  assign misaligned = misaligned_q;
  assign exc_epc    = epc_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    target    = pc_plus4;
    src_valid = 1'b1;
    pop_req   = 1'b0;
    case (pc_source)
      SRC_SEQ:    target = pc_plus4;
      SRC_BRANCH: target = branch_target;
      SRC_JUMP:   target = (pc_plus4 & ~LOW28_MASK) | ADDR_W'({jump_index, 2'b00});
      SRC_REG:    target = reg_target;
      SRC_RAS: begin
        if (ras_empty) begin
          target = reg_target;
        end else begin
          target  = ras_top;
          pop_req = 1'b1;
        end
      end
      SRC_EXC:    target = EXC_PC;
      default:    src_valid = 1'b0;
    endcase
  end

  assign commit    = pc_write_enable & src_valid;
  assign do_push   = commit & ras_push;
  assign do_pop    = commit & pop_req;
  assign bad_align = (target[1:0] != 2'b00);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
      ras_ptr      <= '0;
      ras_cnt      <= '0;
    end else begin
      misaligned_q <= 1'b0;
      if (commit) begin
        if (bad_align) begin
          pc_q         <= EXC_PC;
          epc_q        <= pc_q;
          misaligned_q <= 1'b1;
        end else begin
          pc_q <= target;
        end
        // Push together with pop replaces the top in place; pointer and count stay.
        if (do_push && !do_pop) begin
          ras_ptr <= ras_ptr + PTR_W'(1);
          if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (do_pop && !do_push) begin
          ras_ptr <= top_idx;
          ras_cnt <= ras_cnt - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: stack storage is not reset; the count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      ras_mem[do_pop ? top_idx : ras_ptr] <= pc_plus4;
    end
  end

`ifdef PC_SEQUENCER_TRACE_EN
  logic [ADDR_W-1:0] prev_pc_q;
  logic [15:0]       update_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc_q      <= '0;
      update_count_q <= '0;
    end else if (commit) begin
      prev_pc_q      <= pc_q;
      update_count_q <= update_count_q + 16'd1;
    end
  end

  assign prev_pc      = prev_pc_q;
  assign update_count = update_count_q;
`else
  assign prev_pc      = '0;
  assign update_count = '0;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the multicycle MIPS core.
- Owns the PC register, selects the next-PC source internally (sequential, branch, jump, register, return-stack, exception vector) and keeps a small circular return-address stack (RAS).
- Catches misaligned fetch targets and redirects to the exception vector, latching the faulting PC.
- Sits between the control FSM (pc_write_enable, pc_source) and the instruction-fetch address path.

Parameters:
- ADDR_W, 32, PC width; legal range 28..32.
- RESET_VEC, 0, PC value after reset.
- EXC_VEC, 32'h0000_0180, exception/misalignment target (low ADDR_W bits used).
- RAS_DEPTH, 4, return-address stack entries; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_write_enable  in  1  PC update strobe.
- pc_source  in  3  next-PC select; encoding under Behaviour.
- branch_target  in  ADDR_W  precomputed branch address.
- jump_index  in  26  instruction[25:0] for J/JAL.
- reg_target  in  ADDR_W  rs value for JR/JALR.
- ras_push  in  1  push return address; qualified by pc_write_enable.
- current_pc  out  ADDR_W  registered PC.
- pc_plus4  out  ADDR_W  combinational current_pc+4, modulo 2^ADDR_W.
- ras_top  out  ADDR_W  top RAS entry; 0 when empty.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- misaligned  out  1  registered one-cycle pulse on a misaligned redirect.
- exc_epc  out  ADDR_W  PC at the most recent misaligned redirect.

Behaviour:
- Reset (synchronous, highest priority):
  - current_pc=RESET_VEC; exc_epc=0; misaligned=0.
  - RAS count=0, pointer=0, ras_top=0, ras_empty=1, ras_full=0.
  - Any in-flight push/pop is discarded.
- pc_source encoding, target T:
  - 000: pc_plus4.
  - 001: branch_target.
  - 010: {pc_plus4[ADDR_W-1:28], jump_index, 2'b00}.
  - 011: reg_target.
  - 100: ras_top (pop). If RAS is empty, T=reg_target and no pop occurs.
  - 101: EXC_VEC.
  - 110/111: reserved. PC holds, RAS unchanged, misaligned stays 0.
- No update cycle: if pc_write_enable=0, PC, RAS and exc_epc hold; misaligned=0 next cycle.
- Update cycle, T[1:0]==0: current_pc<=T next edge. Latency is 1 clock; no +4 is applied after selection.
- Update cycle, T[1:0]!=0: current_pc<=EXC_VEC; exc_epc<=current_pc; misaligned=1 for exactly one cycle.
  - The RAS push/pop still commits, so the stack stays consistent with the control flow.
- RAS push (pc_write_enable & ras_push): writes pc_plus4, pointer+1 mod RAS_DEPTH, count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry; ras_full stays 1.
- RAS pop (pc_write_enable & pc_source==100 & !ras_empty): pointer-1 mod RAS_DEPTH, count-1.
- Simultaneous push+pop (JALR through the stack): the top entry is replaced with pc_plus4; pointer and count are unchanged.
- ras_empty, ras_full and ras_top are derived from registered count/pointer; all three are valid in the cycle after an update.
- All additions wrap modulo 2^ADDR_W; no carry out.

Optional Feature:
- Macro: PC_SEQUENCER_TRACE_EN.
- Defined: adds outputs prev_pc (ADDR_W) and update_count (16).
  - prev_pc: value of current_pc before the last committed update, including misaligned redirects.
  - update_count: increments on every committed update, wraps at 16'hFFFF->0.
  - Both reset to 0.
- Undefined: prev_pc and update_count are still present but tied to constant 0; no trace registers are synthesised.

Test Plan:
- Reset: assert reset with RESET_VEC=0x0040_0000 -> current_pc=0x0040_0000, ras_empty=1, misaligned=0. Pulse reset during a push -> RAS count=0.
- Sequential and hold: from 0x0040_0000, 3 cycles pc_source=000 with pc_write_enable=1 -> 0x0040_000C. Then enable=0 for 2 cycles -> PC holds 0x0040_000C.
- Jump: current_pc=0x1000_0000, jump_index=0x0000_100 -> current_pc=0x1000_0400.
- Call/return: JAL at 0x0040_0010 with ras_push -> ras_top=0x0040_0014. Then pc_source=100 -> current_pc=0x0040_0014, ras_empty=1.
- RAS overflow and empty pop (RAS_DEPTH=4):
  - 5 pushes of 0x10,0x20,0x30,0x40,0x50 -> ras_full=1; 4 pops return 0x50,0x40,0x30,0x20.
  - A 5th pop with reg_target=0x0000_0800 -> PC=0x0000_0800, ras_empty stays 1.
- Misaligned: current_pc=0x0040_0020, pc_source=011, reg_target=0x0040_0102 -> current_pc=EXC_VEC, exc_epc=0x0040_0020, misaligned high for exactly 1 cycle.
